mac_reg_arbiter: RTL

//   Shares the Ethernet MAC control-register port (reg_addr/reg_rd/reg_wr/reg_busy) among N_REQ requesters.

---
 rtl/mac_reg_arbiter_if.sv | 33 +++
 rtl/mac_reg_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/mac_reg_arbiter_if.sv
// Requester and MAC control-port signals of the register arbiter.
// slave = arbiter side, master = requesters plus MAC side.
interface mac_reg_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_write;
  logic [8*N_REQ-1:0]  req_addr;
  logic [32*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic [7:0]          mac_reg_addr;
  logic [31:0]         mac_reg_din;
  logic                mac_reg_rd;
  logic                mac_reg_wr;
  logic [31:0]         mac_reg_dout;
  logic                mac_reg_busy;
  logic                arb_busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mac_reg_dout, mac_reg_busy,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mac_reg_addr, mac_reg_din, mac_reg_rd, mac_reg_wr, arb_busy
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mac_reg_dout, mac_reg_busy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mac_reg_addr, mac_reg_din, mac_reg_rd, mac_reg_wr, arb_busy
  );
endinterface

// File: rtl/mac_reg_arbiter.sv
// Round-robin arbiter sharing the MAC control-register port; one transaction in flight.
// Accept -> strobe next cycle -> rsp pulse the cycle after completion; req_ready only in IDLE; busy timeout aborts with rsp_err.
module mac_reg_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  mac_reg_arbiter_if.slave bus
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUS} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] owner;
  logic [GW-1:0] grant;
  logic          grant_vld;
  logic [GW:0]   scan;
  logic          wr_q;
  logic [7:0]    addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          done;
  logic          abort;

  // Scan starts one past the last winner, wrapping at N_REQ.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan = {1'b0, last_grant} + (GW+1)'(k);
      if (scan >= (GW+1)'(N_REQ)) scan = scan - (GW+1)'(N_REQ);
      if (!grant_vld && bus.req_valid[scan[GW-1:0]]) begin
        grant     = scan[GW-1:0];
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    done          = 1'b0;
    abort         = 1'b0;
    bus.req_ready = '0;
    bus.mac_reg_rd = 1'b0;
    bus.mac_reg_wr = 1'b0;
    bus.arb_busy  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          bus.req_ready = N_REQ'(1) << grant;
          accept        = 1'b1;
          state_nxt     = BUS;
        end
      end
      BUS: begin
        bus.arb_busy   = 1'b1;
        bus.mac_reg_rd = ~wr_q;
        bus.mac_reg_wr = wr_q;
        done  = ~bus.mac_reg_busy;
        abort = bus.mac_reg_busy && (cnt == CNT_MAX);
        if (done || abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mac_reg_addr = addr_q;
  assign bus.mac_reg_din  = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= GW'(N_REQ - 1);
      owner         <= '0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt           <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      state         <= state_nxt;
      bus.rsp_valid <= '0;
      bus.rsp_err   <= 1'b0;
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
        wr_q       <= bus.req_write[grant];
        addr_q     <= bus.req_addr[8*grant +: 8];
        wdata_q    <= bus.req_wdata[32*grant +: 32];
        cnt        <= '0;
      end else if (state == BUS && bus.mac_reg_busy) begin
        cnt <= cnt + 1'b1;
      end
      if (done || abort) begin
        bus.rsp_valid <= N_REQ'(1) << owner;
        bus.rsp_err   <= abort;
        // rdata keeps the last read value across writes and timeouts
        if (done && !wr_q) bus.rsp_rdata <= bus.mac_reg_dout;
      end
    end
  end
endmodule
